// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the non-restoring divider:
//   DIV_WIDTH - default operand width (divisor, quotient, remainder)
//   DIV_ITERS - number of ITER cycles (one per quotient bit)
//   state_t   - control-unit FSM states
//   ctrl_t    - one-hot datapath control bits driven by the control unit
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_ITERS = DIV_WIDTH;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LD_AH = 4'd1,
    LD_AL = 4'd2,
    LD_M  = 4'd3,
    CHECK = 4'd4,
    ITER  = 4'd5,
    CORR  = 4'd6,
    OUT_R = 4'd7,
    OUT_Q = 4'd8
  } state_t;

  // At most one bit is high per cycle (all low in IDLE).
  typedef struct packed {
    logic ld_ah;
    logic ld_al;
    logic ld_m;
    logic check;
    logic iter;
    logic corr;
    logic out_r;
    logic out_q;
  } ctrl_t;

endpackage

// File: rtl/cu_divider.sv
// -----------------------------------------------------------------------------
// cu_divider
// Control unit for the non-restoring divider. Sequences operand loads, the
// overflow check, WIDTH iterations, the final correction and the two output
// cycles.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   enable    in   start request, honoured only in IDLE
//   ovf_cond  in   dividend high half >= divisor (valid in CHECK)
//   last_iter in   current ITER cycle is the final one
//   ctrl      out  one-hot datapath control bits
// -----------------------------------------------------------------------------
module cu_divider
  import div_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  enable,
  input  logic  ovf_cond,
  input  logic  last_iter,
  output ctrl_t ctrl
);

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = enable ? LD_AH : IDLE;
      LD_AH:   state_next = LD_AL;
      LD_AL:   state_next = LD_M;
      LD_M:    state_next = CHECK;
      CHECK:   state_next = ovf_cond ? OUT_R : ITER;
      ITER:    state_next = last_iter ? CORR : ITER;
      CORR:    state_next = OUT_R;
      OUT_R:   state_next = OUT_Q;
      OUT_Q:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      LD_AH:   ctrl.ld_ah = 1'b1;
      LD_AL:   ctrl.ld_al = 1'b1;
      LD_M:    ctrl.ld_m  = 1'b1;
      CHECK:   ctrl.check = 1'b1;
      ITER:    ctrl.iter  = 1'b1;
      CORR:    ctrl.corr  = 1'b1;
      OUT_R:   ctrl.out_r = 1'b1;
      OUT_Q:   ctrl.out_q = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// nonrestoring_divider
// Unsigned non-restoring division of a 2*WIDTH-bit dividend A:Q by a WIDTH-bit
// divisor M over a single shared operand/result bus. Operands arrive on three
// consecutive cycles (dividend high, dividend low, divisor); results leave on
// two (remainder, then quotient). Quotient overflow (including divide by zero)
// is detected up front and reported with saturated all-ones results.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   enable  in   start request, honoured only in IDLE
//   inbus   in   WIDTH-bit operand bus
//   done    out  high while a result is on outbus
//   outbus  out  WIDTH-bit result bus, zero when done is low
//   ovf     out  overflow / divide-by-zero flag, only high with done
// -----------------------------------------------------------------------------
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  // Must equal WIDTH: one quotient bit per iteration.
  parameter int ITERS = DIV_ITERS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] inbus,
  output logic             done,
  output logic [WIDTH-1:0] outbus,
  output logic             ovf
);

  localparam int CW = $clog2(ITERS + 1);

  // Partial remainder carries an extra sign bit; it goes negative between
  // iterations and that sign selects add vs. subtract for the next step.
  logic signed [WIDTH:0]   a;
  logic        [WIDTH-1:0] q;
  logic        [WIDTH-1:0] m;
  logic        [CW-1:0]    cnt;
  logic                    ovf_q;

  ctrl_t ctrl;
  logic  ovf_cond;
  logic  last_iter;

  logic signed [WIDTH:0] m_ext;
  logic signed [WIDTH:0] a_shift;
  logic signed [WIDTH:0] a_step;
  logic signed [WIDTH:0] a_corr;

  function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] value,
                                                  input logic             sat);
    return sat ? '1 : value;
  endfunction

  cu_divider u_cu (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .ovf_cond  (ovf_cond),
    .last_iter (last_iter),
    .ctrl      (ctrl)
  );

  // A quotient fits in WIDTH bits only when the high half is below M;
  // M = 0 always trips this.
  assign ovf_cond  = (a[WIDTH-1:0] >= m);
  assign last_iter = (cnt == CW'(ITERS - 1));

  // The shift drops the old sign bit. Since |A| < M, the add/sub result
  // lands back in range, so the modular WIDTH+1-bit arithmetic is exact.
  always_comb begin
    m_ext   = $signed({1'b0, m});
    a_shift = $signed({a[WIDTH-1:0], q[WIDTH-1]});
    a_step  = a[WIDTH] ? (a_shift + m_ext) : (a_shift - m_ext);
    a_corr  = a[WIDTH] ? (a + m_ext) : a;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a     <= '0;
      q     <= '0;
      m     <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (ctrl.ld_ah) a <= $signed({1'b0, inbus});
      if (ctrl.ld_al) q <= inbus;
      if (ctrl.ld_m)  m <= inbus;
      if (ctrl.check) begin
        cnt   <= '0;
        ovf_q <= ovf_cond;
      end
      if (ctrl.iter) begin
        a   <= a_step;
        q   <= {q[WIDTH-2:0], ~a_step[WIDTH]};
        cnt <= cnt + CW'(1);
      end
      if (ctrl.corr) a <= a_corr;
    end
  end

  always_comb begin
    done   = ctrl.out_r | ctrl.out_q;
    ovf    = ovf_q & done;
    outbus = '0;
    if (ctrl.out_r)      outbus = sat_result(a[WIDTH-1:0], ovf_q);
    else if (ctrl.out_q) outbus = sat_result(q, ovf_q);
  end

endmodule

// File: doc/nonrestoring_divider.md
NONRESTORING_DIVIDER -- requirements
Module: nonrestoring_divider

Interface
REQ-001 SHALL have parameter: WIDTH, 8, bus/divisor/quotient/remainder width; dividend is 2*WIDTH bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: enable  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port: inbus  input  WIDTH  operand bus (dividend high, dividend low, divisor, in that order).
REQ-006 SHALL have port: done  output  1  high while results are driven on outbus.
REQ-007 SHALL have port: outbus  output  WIDTH  result bus (remainder, then quotient).
REQ-008 SHALL have port: ovf  output  1  quotient-overflow / divide-by-zero flag, valid while done=1.

Function
REQ-009 SHALL perform unsigned non-restoring division of a 2*WIDTH-bit dividend A:Q by WIDTH-bit divisor M.
REQ-010 SHALL implement FSM states IDLE, LD_AH, LD_AL, LD_M, CHECK, ITER, CORR, OUT_R, OUT_Q.
REQ-011 IDLE: enable=1 at an edge -> LD_AH; otherwise stay in IDLE.
REQ-012 LD_AH/LD_AL/LD_M: each captures inbus at the end of its cycle into A, Q, M respectively; the next state follows unconditionally.
REQ-013 CHECK: if A >= M (includes M=0) -> OUT_R with ovf set; else -> ITER with iteration counter cleared.
REQ-014 ITER: one iteration per cycle, exactly WIDTH cycles; A SHALL be held in WIDTH+1 bits (sign bit).
REQ-015 Each iteration: shift A:Q left by 1; if the prior A is non-negative, subtract M, else add M; then set Q[0] = NOT(new A sign).
REQ-016 After the final iteration -> CORR: if A is negative, add M; A[WIDTH-1:0] is then the remainder.
REQ-017 OUT_R: outbus = remainder, done=1; OUT_Q: outbus = quotient, done=1; then -> IDLE.
REQ-018 On overflow: outbus SHALL be all-ones in OUT_R and OUT_Q, ovf=1 in both cycles; otherwise ovf=0.
REQ-019 Latency: with enable sampled at edge 0, operands SHALL be taken from cycles 1-3, CHECK in cycle 4, ITER in cycles 5-12, CORR in cycle 13, and done=1 in cycles 14-15 (4 and 5-6 on overflow).
REQ-020 outbus SHALL be 0 and done=0 in every state other than OUT_R/OUT_Q.
REQ-021 enable SHALL be ignored outside IDLE; enable held high SHALL cause back-to-back operations, the next LD_AH following OUT_Q->IDLE.
REQ-022 Results SHALL not depend on inbus outside the three load cycles.

Reset
REQ-023 rst_n=0 at an edge SHALL force IDLE and clear A, Q, M, the counter, and ovf, in any state including mid-iteration.
REQ-024 During and after reset: done=0, ovf=0, outbus=0 until a new operation reaches OUT_R.

Structure
REQ-025 Shared package div_pkg SHALL hold the FSM state enum, default WIDTH, and the iteration count constant.
REQ-026 The FSM SHALL be a sub-module cu_divider that drives one-hot datapath control bits; the datapath (registers, add/sub, counter) SHALL stay in nonrestoring_divider.

Verification
REQ-027 Scenario: inbus 0x03,0xE8,0x07 (1000/7) -> cycle 14 outbus=0x06 done=1 ovf=0; cycle 15 outbus=0x8E.
REQ-028 Scenario: inbus 0x12,0x34,0x56 (4660/86) -> remainder 0x10, quotient 0x36.
REQ-029 Scenario: inbus 0x00,0xFF,0x01 -> remainder 0x00, quotient 0xFF, ovf=0.
REQ-030 Scenario: divisor 0x00 (0x00,0x64,0x00) and 0xFF,0xFF,0xFF -> ovf=1, outbus=0xFF for two done cycles starting cycle 5.
REQ-031 Scenario: rst_n=0 in cycle 8 of 1000/7 -> next cycle IDLE, done=0, outbus=0; a fresh 1000/7 gives the correct result.
REQ-032 Scenario: enable held high across two operations, and enable pulsed mid-ITER -> only queued starts from IDLE; both results correct, no extra done cycles.
